// File: rtl/dual_debounce.sv
// Two-channel switch conditioner: a two-flop synchroniser and a bounce
// filter per channel, with registered level outputs and one-cycle
// rise/fall pulses. The two channels share no state.
module dual_debounce #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_1,
    input  logic raw_2,
    output logic out_1,
    output logic out_2,
    output logic rise_1,
    output logic rise_2,
    output logic fall_1,
    output logic fall_2
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Bit 0 is channel 1, bit 1 is channel 2.
    logic [1:0]            raw;
    logic [1:0]            s1_q;
    logic [1:0]            s2_q;
    logic [1:0]            out_q;
    logic [1:0]            out_d;
    logic [1:0]            rise_q;
    logic [1:0]            rise_d;
    logic [1:0]            fall_q;
    logic [1:0]            fall_d;
    logic [1:0][CNT_W-1:0] cnt_q;
    logic [1:0][CNT_W-1:0] cnt_d;

    assign raw = {raw_2, raw_1};

    // Filter: count consecutive cycles the synchronised level disagrees
    // with the output; follow it once the count reaches the threshold.
    always_comb begin
        out_d  = out_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            if (s2_q[ch] == out_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                out_d[ch]  = s2_q[ch];
                cnt_d[ch]  = '0;
                rise_d[ch] = s2_q[ch];
                fall_d[ch] = ~s2_q[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    // State registers: synchroniser, counters, levels and pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out_1  = out_q[0];
    assign out_2  = out_q[1];
    assign rise_1 = rise_q[0];
    assign rise_2 = rise_q[1];
    assign fall_1 = fall_q[0];
    assign fall_2 = fall_q[1];

endmodule

// File: tb/tb_dual_debounce.sv
// Bench for dual_debounce with STABLE_CYCLES=4: a fixed vector table,
// directed multi-cycle sequences and randomized stimulus compared against
// a history-window reference model.
module tb_dual_debounce;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw_1 = 1'b0;
    logic raw_2 = 1'b0;
    logic out_1, out_2, rise_1, rise_2, fall_1, fall_2;

    int tests = 0;
    int fails = 0;

    dual_debounce #(.STABLE_CYCLES(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_1  (raw_1),
        .raw_2  (raw_2),
        .out_1  (out_1),
        .out_2  (out_2),
        .rise_1 (rise_1),
        .rise_2 (rise_2),
        .fall_1 (fall_1),
        .fall_2 (fall_2)
    );

    always #5 clk = ~clk;

    // Reference model: the synchronised level seen at each edge is logged;
    // the output follows when the last N logged values since the last
    // change/reset all disagree with it.
    bit ms1 [2];
    bit ms2 [2];
    bit mout [2];
    bit mrise [2];
    bit mfall [2];
    int last_ev [2];
    bit hist [2][8192];
    int ek = 0;

    // Per-hold statistics (first edge index, 1-based; 0 = never).
    int first_r1, first_r2, first_f1, first_f2, first_and;
    int cnt_r1, cnt_r2, cnt_f1, cnt_f2;

    typedef struct {
        logic       rst;
        logic       r1;
        logic       r2;
        logic [5:0] exp;   // {out_2,out_1,rise_2,rise_1,fall_2,fall_1}
    } vec_t;
    vec_t tbl [17];

    function automatic logic [5:0] dut_vec();
        return {out_2, out_1, rise_2, rise_1, fall_2, fall_1};
    endfunction

    function automatic logic [5:0] model_vec();
        return {mout[1], mout[0], mrise[1], mrise[0], mfall[1], mfall[0]};
    endfunction

    task automatic model_edge();
        bit raw [2];
        bit ok;
        raw[0] = raw_1;
        raw[1] = raw_2;
        ek++;
        for (int ch = 0; ch < 2; ch++) begin
            mrise[ch] = 1'b0;
            mfall[ch] = 1'b0;
            if (!rst_n) begin
                ms1[ch] = 1'b0;
                ms2[ch] = 1'b0;
                mout[ch] = 1'b0;
                last_ev[ch] = ek;
            end else begin
                hist[ch][ek] = ms2[ch];
                if (ek - last_ev[ch] >= N) begin
                    ok = 1'b1;
                    for (int j = ek - N + 1; j <= ek; j++)
                        if (hist[ch][j] == mout[ch]) ok = 1'b0;
                    if (ok) begin
                        mout[ch] = ms2[ch];
                        mrise[ch] = ms2[ch];
                        mfall[ch] = ~ms2[ch];
                        last_ev[ch] = ek;
                    end
                end
                ms2[ch] = ms1[ch];
                ms1[ch] = raw[ch];
            end
        end
    endtask

    task automatic step(input logic r, input logic a, input logic b);
        @(negedge clk);
        rst_n = r;
        raw_1 = a;
        raw_2 = b;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Apply a fixed input for n edges, checking against the model each edge.
    task automatic hold(input string name, input int n, input logic r, input logic a, input logic b);
        first_r1 = 0; first_r2 = 0; first_f1 = 0; first_f2 = 0; first_and = 0;
        cnt_r1 = 0; cnt_r2 = 0; cnt_f1 = 0; cnt_f2 = 0;
        for (int i = 1; i <= n; i++) begin
            step(r, a, b);
            check_vec(name, dut_vec(), model_vec());
            if (rise_1) begin cnt_r1++; if (first_r1 == 0) first_r1 = i; end
            if (rise_2) begin cnt_r2++; if (first_r2 == 0) first_r2 = i; end
            if (fall_1) begin cnt_f1++; if (first_f1 == 0) first_f1 = i; end
            if (fall_2) begin cnt_f2++; if (first_f2 == 0) first_f2 = i; end
            if ((out_1 & out_2) && first_and == 0) first_and = i;
        end
    endtask

    initial begin
        // Reset with raw high, release, then drop raw_1 (values derived by hand).
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 6'b00_00_00};
        for (int i = 3; i < 8; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 6'b00_00_00};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 6'b11_11_00};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 6'b11_00_00};
        for (int i = 10; i < 15; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 6'b11_00_00};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 6'b10_00_01};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 6'b10_00_00};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst, tbl[i].r1, tbl[i].r2);
            check_vec($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
        end

        // Clean step on channel 1 from a fresh reset.
        hold("rst_clear", 2, 1'b0, 1'b0, 1'b0);
        hold("idle", 4, 1'b1, 1'b0, 1'b0);
        hold("clean_step", 10, 1'b1, 1'b1, 1'b0);
        check_int("clean_rise1_edge", first_r1, 6);
        check_int("clean_rise1_count", cnt_r1, 1);
        check_int("clean_rise2_count", cnt_r2, 0);
        check_int("clean_out2", int'(out_2), 0);

        // Bounce: toggle 10 cycles, then settle high.
        hold("bounce_low", 10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i % 2 == 0), 1'b0);
            check_vec("bounce", dut_vec(), model_vec());
            check_int("bounce_out1_low", int'(out_1), 0);
        end
        hold("bounce_settle", 12, 1'b1, 1'b1, 1'b0);
        check_int("bounce_rise1_edge", first_r1, 6);

        // Short glitch on channel 2: 3 cycles high is below threshold.
        hold("glitch_hi", 3, 1'b1, 1'b1, 1'b1);
        check_int("glitch_rise2_hi", cnt_r2, 0);
        hold("glitch_lo", 10, 1'b1, 1'b1, 1'b0);
        check_int("glitch_rise2_lo", cnt_r2, 0);
        check_int("glitch_out2", int'(out_2), 0);

        // Fall interrupted by reset after 3 edges.
        hold("fall_start", 3, 1'b1, 1'b0, 1'b0);
        check_int("fall_abort_fall1", cnt_f1, 0);
        hold("fall_reset", 1, 1'b0, 1'b0, 1'b0);
        check_int("fall_reset_out1", int'(out_1), 0);
        check_int("fall_reset_fall1", cnt_f1, 0);
        hold("rehigh", 10, 1'b1, 1'b1, 1'b0);
        hold("full_fall", 10, 1'b1, 1'b0, 1'b0);
        check_int("fall1_edge", first_f1, 6);
        check_int("fall1_count", cnt_f1, 1);

        // Both channels step on the same edge.
        hold("both_low", 8, 1'b1, 1'b0, 1'b0);
        hold("both_step", 10, 1'b1, 1'b1, 1'b1);
        check_int("both_rise1_edge", first_r1, 6);
        check_int("both_rise2_edge", first_r2, 6);
        check_int("and_stage_edge", first_and, 6);

        // Randomized segments, occasional reset.
        for (int s = 0; s < 150; s++) begin
            hold("random", int'($urandom_range(1, 7)),
                 logic'($urandom_range(0, 39) != 0),
                 logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
